// File: rtl/prim_mem_responder_pkg.sv
// Prim bus encodings shared by the responder: byte-select codes, opcodes, FSM states.
package prim_mem_responder_pkg;

  localparam logic [1:0] BS_NONE    = 2'b00;
  localparam logic [1:0] BS_BYTE    = 2'b01;
  localparam logic [1:0] BS_WORD    = 2'b11;
  localparam logic [1:0] BS_ILLEGAL = 2'b10;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAITST,
    ST_BYTE0,
    ST_BYTE1,
    ST_DONE
  } state_e;

  // Second byte of a word wraps within the 16-bit bus address space.
  function automatic logic [15:0] next_byte_addr(input logic [15:0] a);
    return a + 16'd1;
  endfunction

endpackage

// File: rtl/prim_mem_responder_ram.sv
// Single-port byte RAM: synchronous write, registered read (1 cycle).
module prim_byte_ram #(
  parameter int    AW        = 12,
  parameter string INIT_FILE = ""
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdat,
  output logic [7:0]    o_rdat
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr] <= i_wdat;
    o_rdat <= mem[i_addr];
  end

endmodule

// File: rtl/prim_mem_responder.sv
// Prim bus memory slave: byte/word access, ack after 2+WAIT (byte) or 3+WAIT (word) cycles.
// No backpressure: one request is latched in IDLE and inputs are ignored until its ack.
module prim_mem_responder
  import prim_mem_responder_pkg::*;
#(
  parameter int    AW        = 12,
  parameter int    WAIT      = 0,
  parameter string INIT_FILE = ""
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_dat,
  output logic [15:0] o_dat,
  input  logic [1:0]  i_bs,
  input  logic        i_we,
  output logic        o_ack
);

  localparam logic [2:0] WAIT_LAST = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdat_q, wdat_d;
  logic [15:0] rdat_q, rdat_d;
  logic [1:0]  bs_q, bs_d;
  logic        we_q, we_d;
  logic [7:0]  lo_q, lo_d;

  logic [15:0]   addr_p1;
  logic [15:0]   result;
  logic          is_word, legal;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdat, ram_rdat;
  logic          unused_addr_hi;

  assign is_word        = (bs_q == BS_WORD);
  assign legal          = (bs_q != BS_ILLEGAL);
  assign addr_p1        = next_byte_addr(addr_q);
  assign unused_addr_hi = ^addr_p1[15:AW];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    rdat_d   = rdat_q;
    bs_d     = bs_q;
    we_d     = we_q;
    lo_d     = lo_q;
    ram_we   = 1'b0;
    ram_addr = addr_q[AW-1:0];
    ram_wdat = wdat_q[7:0];
    result   = 16'h0000;
    unique case (state_q)
      ST_IDLE: begin
        if (i_bs != BS_NONE) begin
          addr_d  = i_addr;
          wdat_d  = i_dat;
          bs_d    = i_bs;
          we_d    = i_we;
          cnt_d   = 3'd0;
          state_d = (WAIT > 0) ? ST_WAITST : ST_BYTE0;
        end
      end
      ST_WAITST: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = 3'd0;
          state_d = ST_BYTE0;
        end
      end
      ST_BYTE0: begin
        ram_we  = legal && (we_q == OP_WRITE);
        state_d = is_word ? ST_BYTE1 : ST_DONE;
      end
      ST_BYTE1: begin
        ram_addr = addr_p1[AW-1:0];
        ram_wdat = wdat_q[15:8];
        ram_we   = (we_q == OP_WRITE);
        lo_d     = ram_rdat;  // registered read of mem[A] issued in BYTE0
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (!legal)                result = 16'h0000;
        else if (we_q == OP_WRITE) result = rdat_q;
        else if (is_word)          result = {ram_rdat, lo_q};
        else                       result = {8'h00, ram_rdat};
        rdat_d  = result;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= 16'h0000;
      wdat_q  <= 16'h0000;
      rdat_q  <= 16'h0000;
      bs_q    <= BS_NONE;
      we_q    <= OP_READ;
      lo_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      bs_q    <= bs_d;
      we_q    <= we_d;
      lo_q    <= lo_d;
    end
  end

  assign o_ack = (state_q == ST_DONE);
  assign o_dat = o_ack ? result : rdat_q;

  prim_byte_ram #(
    .AW       (AW),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .i_clk (i_clk),
    .i_we  (ram_we),
    .i_addr(ram_addr),
    .i_wdat(ram_wdat),
    .o_rdat(ram_rdat)
  );

endmodule
